// File: rtl/ir_seq.sv
// Instruction-register sequencer: fetch, load, decode, immediate drive and
// execute hand-off, with fetch timeout, illegal-immediate fault and retire count.
module ir_seq #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  output logic             mem_rd,
  input  logic             mem_ack,
  output logic             ir_ld,
  output logic             pc_inc,
  input  logic [1:0]       imm_sel,
  input  logic             imm_port,
  output logic             oe_a_8,
  output logic             oe_a_16,
  output logic             oe_b_8,
  output logic             oe_b_16,
  output logic             exec_start,
  input  logic             exec_done,
  input  logic             fault_clr,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TO_EN = (TIMEOUT > 0);

  // EXEC is split so exec_start stays a pure decode of the first EXEC cycle.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_DECODE = 3'd3,
    S_IMM    = 3'd4,
    S_EXEC1  = 3'd5,
    S_EXECW  = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic mem_rd_q, mem_rd_d, ir_ld_q, ir_ld_d, pc_inc_q, pc_inc_d;
  logic oe_a_8_q, oe_a_8_d, oe_a_16_q, oe_a_16_d, oe_b_8_q, oe_b_8_d, oe_b_16_q, oe_b_16_d;
  logic exec_start_q, exec_start_d, busy_q, busy_d, fault_q, fault_d;

  // Next state, wait counter and retire counter.
  always_comb begin
    state_d   = state_q;
    wait_d    = {WAIT_W{1'b0}};
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (start && !halt) state_d = S_FETCH;
        else                state_d = S_IDLE;
      end
      S_FETCH: begin
        if (mem_ack)                          state_d = S_LOAD;
        else if (TO_EN && wait_q == WAIT_LAST) state_d = S_FAULT;
        else                                  wait_d  = wait_q + WAIT_W'(1);
      end
      S_LOAD:   state_d = S_DECODE;
      S_DECODE: begin
        case (imm_sel)
          2'd0:       state_d = S_EXEC1;
          2'd1, 2'd2: state_d = S_IMM;
          default:    state_d = S_FAULT;
        endcase
      end
      S_IMM:    state_d = S_EXEC1;
      S_EXEC1, S_EXECW: begin
        if (exec_done) begin
          retired_d = retired_q + CNT_W'(1);
          state_d   = halt ? S_IDLE : S_FETCH;
        end else begin
          state_d   = S_EXECW;
        end
      end
      S_FAULT: begin
        if (fault_clr) state_d = S_IDLE;
        else           state_d = S_FAULT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output flops hold the decode of the state being entered; imm_sel/port are
  // only meaningful here on the DECODE->IMM transition.
  always_comb begin
    mem_rd_d     = (state_d == S_FETCH);
    ir_ld_d      = (state_d == S_LOAD);
    pc_inc_d     = (state_d == S_LOAD);
    exec_start_d = (state_d == S_EXEC1);
    busy_d       = (state_d != S_IDLE) && (state_d != S_FAULT);
    fault_d      = (state_d == S_FAULT);
    oe_a_8_d     = (state_d == S_IMM) && (imm_sel == 2'd1) && !imm_port;
    oe_b_8_d     = (state_d == S_IMM) && (imm_sel == 2'd1) &&  imm_port;
    oe_a_16_d    = (state_d == S_IMM) && (imm_sel == 2'd2) && !imm_port;
    oe_b_16_d    = (state_d == S_IMM) && (imm_sel == 2'd2) &&  imm_port;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wait_q       <= {WAIT_W{1'b0}};
      retired_q    <= {CNT_W{1'b0}};
      mem_rd_q     <= 1'b0;
      ir_ld_q      <= 1'b0;
      pc_inc_q     <= 1'b0;
      oe_a_8_q     <= 1'b0;
      oe_a_16_q    <= 1'b0;
      oe_b_8_q     <= 1'b0;
      oe_b_16_q    <= 1'b0;
      exec_start_q <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      retired_q    <= retired_d;
      mem_rd_q     <= mem_rd_d;
      ir_ld_q      <= ir_ld_d;
      pc_inc_q     <= pc_inc_d;
      oe_a_8_q     <= oe_a_8_d;
      oe_a_16_q    <= oe_a_16_d;
      oe_b_8_q     <= oe_b_8_d;
      oe_b_16_q    <= oe_b_16_d;
      exec_start_q <= exec_start_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
    end
  end

  assign mem_rd     = mem_rd_q;
  assign ir_ld      = ir_ld_q;
  assign pc_inc     = pc_inc_q;
  assign oe_a_8     = oe_a_8_q;
  assign oe_a_16    = oe_a_16_q;
  assign oe_b_8     = oe_b_8_q;
  assign oe_b_16    = oe_b_16_q;
  assign exec_start = exec_start_q;
  assign busy       = busy_q;
  assign fault      = fault_q;
  assign retired    = retired_q;

endmodule
